// File: rtl/prbs_pkg.sv
// prbs_pkg
// Shared types and helpers for the PRBS checker.
//   prbs_sel_e    : run-time polynomial select (PRBS7/15/23/31)
//   chk_state_e   : lock FSM states (SEARCH, LOCKED)
//   TAP_A / TAP_B : feedback taps per polynomial; TAP_A is also the order N
//   prbs_predict  : next expected bit from the history register
//   prbs_nonzero  : true when the low N history bits are not all zero
package prbs_pkg;

  typedef enum logic [1:0] {
    PRBS7  = 2'd0,
    PRBS15 = 2'd1,
    PRBS23 = 2'd2,
    PRBS31 = 2'd3
  } prbs_sel_e;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } chk_state_e;

  localparam int SR_W = 31;

  // x^A + x^B + 1, indexed by prbs_sel_e
  localparam logic [4:0] TAP_A [4] = '{5'd7, 5'd15, 5'd23, 5'd31};
  localparam logic [4:0] TAP_B [4] = '{5'd6, 5'd14, 5'd18, 5'd28};

  // sr[0] holds the newest bit, so tap k sits at sr[k-1]
  function automatic logic prbs_predict(input logic [SR_W-1:0] sr, input prbs_sel_e sel);
    return sr[TAP_A[sel] - 5'd1] ^ sr[TAP_B[sel] - 5'd1];
  endfunction

  // An all-zero history predicts all zeros forever; it must never count as a match
  function automatic logic prbs_nonzero(input logic [SR_W-1:0] sr, input prbs_sel_e sel);
    logic [SR_W-1:0] mask;
    mask = {SR_W{1'b1}} >> (5'd31 - TAP_A[sel]);
    return |(sr & mask);
  endfunction

endpackage

// File: rtl/prbs_checker_lock_err_window.sv
// prbs_err_window
// Loss-of-lock detector: counts valid bits in fixed windows of UNLOCK_WINDOW
// and errors within the current window. o_unlock strobes (combinationally) on
// the valid errored bit that brings the window error count to UNLOCK_ERRORS;
// that takes priority over a window wrap on the same bit.
// Ports:
//   clk, rstn  : clock, async active-low reset
//   i_restart  : hold both counters at zero (checker not locked)
//   i_vld      : a bit is being checked this cycle
//   i_err      : that bit is in error
//   o_unlock   : threshold reached on this bit
module prbs_err_window
  import prbs_pkg::*;
#(
  parameter int UNLOCK_WINDOW = 64,
  parameter int UNLOCK_ERRORS = 8
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_restart,
  input  logic i_vld,
  input  logic i_err,
  output logic o_unlock
);

  localparam int WIN_W = (UNLOCK_WINDOW > 1) ? $clog2(UNLOCK_WINDOW) : 1;
  localparam int ERR_W = $clog2(UNLOCK_ERRORS + 1);

  logic [WIN_W-1:0] r_win_cnt;
  logic [ERR_W-1:0] r_err_cnt;
  logic             w_last;

  assign w_last   = (r_win_cnt == WIN_W'(UNLOCK_WINDOW - 1));
  assign o_unlock = i_vld & i_err & (r_err_cnt == ERR_W'(UNLOCK_ERRORS - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_win_cnt <= '0;
      r_err_cnt <= '0;
    end else if (i_restart) begin
      r_win_cnt <= '0;
      r_err_cnt <= '0;
    end else if (i_vld) begin
      if (w_last) begin
        r_win_cnt <= '0;
        r_err_cnt <= '0;
      end else begin
        r_win_cnt <= r_win_cnt + WIN_W'(1);
        r_err_cnt <= r_err_cnt + ERR_W'(i_err);
      end
    end
  end

endmodule

// File: rtl/prbs_checker_lock.sv
// prbs_checker_lock
// Self-synchronising PRBS7/15/23/31 checker with lock FSM and BER counters.
// In SEARCH the history register follows the received data until LOCK_COUNT
// consecutive bits match the prediction; in LOCKED it free-runs on its own
// prediction and every valid bit is compared against it. Counters only move
// while locked.
// Optional feature macro: PRBS_CHK_LOSS_CNT_EN adds lock_loss_count.
// Ports:
//   clk, rstn            : clock, async active-low reset
//   data_in/_valid       : recovered bit and its qualifier
//   prbs_sel             : polynomial select (prbs_sel_e encoding)
//   clear                : synchronous clear of the statistics counters
//   locked               : FSM is in LOCKED
//   error_pulse          : one cycle per errored bit checked while locked
//   total_bits           : saturating count of checked bits
//   total_bit_errors     : saturating count of errored bits
//   lock_loss_count      : (optional) saturating count of error-driven lock losses
module prbs_checker_lock
  import prbs_pkg::*;
#(
  parameter int CNT_WIDTH     = 32,
  parameter int LOCK_COUNT    = 64,
  parameter int UNLOCK_WINDOW = 64,
  parameter int UNLOCK_ERRORS = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 data_in,
  input  logic                 data_in_valid,
  input  logic [1:0]           prbs_sel,
  input  logic                 clear,
  output logic                 locked,
  output logic                 error_pulse,
  output logic [CNT_WIDTH-1:0] total_bits,
  output logic [CNT_WIDTH-1:0] total_bit_errors
`ifdef PRBS_CHK_LOSS_CNT_EN
  ,
  output logic [15:0]          lock_loss_count
`endif
);

  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);

  chk_state_e           r_state, w_state_nxt;
  prbs_sel_e            r_sel;
  logic [SR_W-1:0]      r_sr, w_sr_nxt;
  logic [4:0]           r_fill_cnt, w_fill_nxt;
  logic [MATCH_W-1:0]   r_match_cnt, w_match_nxt;
  logic                 r_err_pulse;
  logic [CNT_WIDTH-1:0] r_total_bits, r_total_errs;

  logic w_sel_chg, w_pred, w_fill_done, w_match, w_err, w_lk_vld, w_unlock;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  // A select change is seen against the registered copy; that cycle's bit is dropped
  assign w_sel_chg   = (prbs_sel != r_sel);
  assign w_pred      = prbs_predict(r_sr, r_sel);
  assign w_fill_done = (r_fill_cnt == TAP_A[r_sel]);
  assign w_match     = (data_in == w_pred) && prbs_nonzero(r_sr, r_sel);
  assign w_err       = data_in ^ w_pred;
  assign w_lk_vld    = (r_state == LOCKED) && data_in_valid && !w_sel_chg;

  prbs_err_window #(
    .UNLOCK_WINDOW(UNLOCK_WINDOW),
    .UNLOCK_ERRORS(UNLOCK_ERRORS)
  ) u_err_window (
    .clk      (clk),
    .rstn     (rstn),
    .i_restart((r_state != LOCKED) || w_sel_chg),
    .i_vld    (w_lk_vld),
    .i_err    (w_err),
    .o_unlock (w_unlock)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= SEARCH;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sr_nxt    = r_sr;
    w_fill_nxt  = r_fill_cnt;
    w_match_nxt = r_match_cnt;
    if (w_sel_chg) begin
      w_state_nxt = SEARCH;
      w_fill_nxt  = '0;
      w_match_nxt = '0;
    end else if (data_in_valid) begin
      unique case (r_state)
        SEARCH: begin
          w_sr_nxt = {r_sr[SR_W-2:0], data_in};
          if (!w_fill_done) begin
            w_fill_nxt = r_fill_cnt + 5'd1;
          end else if (w_match) begin
            w_match_nxt = r_match_cnt + MATCH_W'(1);
            if (r_match_cnt == MATCH_W'(LOCK_COUNT - 1)) w_state_nxt = LOCKED;
          end else begin
            w_match_nxt = '0;
          end
        end
        LOCKED: begin
          // Reference free-runs so errored input bits do not corrupt it
          w_sr_nxt = {r_sr[SR_W-2:0], w_pred};
          if (w_unlock) begin
            w_state_nxt = SEARCH;
            w_fill_nxt  = '0;
            w_match_nxt = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sel        <= PRBS7;
      r_sr         <= '0;
      r_fill_cnt   <= '0;
      r_match_cnt  <= '0;
      r_err_pulse  <= 1'b0;
      r_total_bits <= '0;
      r_total_errs <= '0;
    end else begin
      r_sel       <= prbs_sel_e'(prbs_sel);
      r_sr        <= w_sr_nxt;
      r_fill_cnt  <= w_fill_nxt;
      r_match_cnt <= w_match_nxt;
      r_err_pulse <= w_lk_vld & w_err;
      if (clear) begin
        r_total_bits <= '0;
        r_total_errs <= '0;
      end else if (w_lk_vld) begin
        r_total_bits <= sat_inc(r_total_bits);
        if (w_err) r_total_errs <= sat_inc(r_total_errs);
      end
    end
  end

`ifdef PRBS_CHK_LOSS_CNT_EN
  logic [15:0] r_loss_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                         r_loss_cnt <= '0;
    else if (clear)                    r_loss_cnt <= '0;
    else if (w_lk_vld && w_unlock && !(&r_loss_cnt)) r_loss_cnt <= r_loss_cnt + 16'd1;
  end

  assign lock_loss_count = r_loss_cnt;
`endif

  assign locked           = (r_state == LOCKED);
  assign error_pulse      = r_err_pulse;
  assign total_bits       = r_total_bits;
  assign total_bit_errors = r_total_errs;

endmodule

// File: tb/tb_prbs_checker_lock.sv
`timescale 1ns/1ps
module tb_prbs_checker_lock;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        data_in = 1'b0;
  logic        data_in_valid = 1'b0;
  logic        clear = 1'b0;
  logic [1:0]  prbs_sel = 2'd3;
  logic        locked, error_pulse, locked_s, error_pulse_s;
  logic [31:0] total_bits, total_bit_errors;
  logic [3:0]  tb_s, te_s;
`ifdef PRBS_CHK_LOSS_CNT_EN
  logic [15:0] llc, llc_s;
`endif

  always #5 clk = ~clk;

  prbs_checker_lock #(.CNT_WIDTH(32)) dut (
    .clk(clk), .rstn(rstn), .data_in(data_in), .data_in_valid(data_in_valid),
    .prbs_sel(prbs_sel), .clear(clear), .locked(locked), .error_pulse(error_pulse),
    .total_bits(total_bits), .total_bit_errors(total_bit_errors)
`ifdef PRBS_CHK_LOSS_CNT_EN
    , .lock_loss_count(llc)
`endif
  );

  // Narrow-counter instance on the same stream, for saturation
  prbs_checker_lock #(.CNT_WIDTH(4)) dut_s (
    .clk(clk), .rstn(rstn), .data_in(data_in), .data_in_valid(data_in_valid),
    .prbs_sel(prbs_sel), .clear(clear), .locked(locked_s), .error_pulse(error_pulse_s),
    .total_bits(tb_s), .total_bit_errors(te_s)
`ifdef PRBS_CHK_LOSS_CNT_EN
    , .lock_loss_count(llc_s)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;
  localparam int NEVER = 1 << 30;

  typedef struct packed { logic lk; logic ep; } exp_t;
  exp_t sb[$];

  logic [30:0] g;
  int          gsel;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic gen(output logic b);
    int ta, tb;
    case (gsel)
      0:       begin ta = 7;  tb = 6;  end
      1:       begin ta = 15; tb = 14; end
      2:       begin ta = 23; tb = 18; end
      default: begin ta = 31; tb = 28; end
    endcase
    b = g[ta-1] ^ g[tb-1];
    g = {g[29:0], b};
  endtask

  task automatic step(input logic b, input logic v, input logic clr,
                      input logic elk, input logic eep, input string tag);
    exp_t e;
    sb.push_back(exp_t'{lk: elk, ep: eep});
    @(negedge clk);
    data_in = b; data_in_valid = v; clear = clr;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, "_locked"}, 32'(locked), 32'(e.lk));
    chk({tag, "_errpulse"}, 32'(error_pulse), 32'(e.ep));
  endtask

  // n generator bits; expected locked after bit i is lock_from <= i < lock_until
  task automatic run(input int n, input int lock_from, input int lock_until,
                     input logic [63:0] flips, input string tag);
    logic b, f;
    for (int i = 0; i < n; i++) begin
      gen(b);
      f = (i < 64) ? flips[i] : 1'b0;
      step(b ^ f, 1'b1, 1'b0, (i >= lock_from) && (i < lock_until), f, tag);
    end
  endtask

  initial begin
    logic b;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_errpulse", 32'(error_pulse), 32'd0);
    chk("rst_bits", total_bits, 32'd0);
    chk("rst_errs", total_bit_errors, 32'd0);
`ifdef PRBS_CHK_LOSS_CNT_EN
    chk("rst_loss", 32'(llc), 32'd0);
`endif
    @(negedge clk);
    rstn = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "idle");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "idle");

    // PRBS31 acquisition: 31 fill + 64 matches
    gsel = 3; g = 31'h1;
    run(95, 94, NEVER, 64'h0, "lock31");
    chk("lock31_bits", total_bits, 32'd0);
    run(1000, 0, NEVER, 64'h0, "clean31");
    chk("clean31_bits", total_bits, 32'd1000);
    chk("clean31_errs", total_bit_errors, 32'd0);
    chk("clean31_bits_sat4", 32'(tb_s), 32'd15);
    chk("clean31_errs_sat4", 32'(te_s), 32'd0);

    // 8 errors inside one window -> loss of lock on the 8th
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "clr");
    chk("clr_bits", total_bits, 32'd0);
    chk("clr_errs", total_bit_errors, 32'd0);
    run(15, 0, 14, 64'h5555, "burst");
    chk("burst_bits", total_bits, 32'd15);
    chk("burst_errs", total_bit_errors, 32'd8);
`ifdef PRBS_CHK_LOSS_CNT_EN
    chk("burst_loss", 32'(llc), 32'd1);
`endif
    run(95, 94, NEVER, 64'h0, "relock31");
    chk("relock31_bits", total_bits, 32'd15);
    chk("relock31_errs", total_bit_errors, 32'd8);

    // Select change 3 -> 1 drops lock without counting as a loss
    prbs_sel = 2'd1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "sel31to15");
    gsel = 1; g = 31'h1;
    run(79, 78, NEVER, 64'h0, "lock15");
`ifdef PRBS_CHK_LOSS_CNT_EN
    chk("sel_loss", 32'(llc), 32'd1);
`endif

    // PRBS7 with three isolated errors
    prbs_sel = 2'd0;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "sel15to7");
    gsel = 0; g = 31'h1;
    run(71, 70, NEVER, 64'h0, "lock7");
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "clr7");
    run(40, 0, NEVER, 64'h4002_0020, "err7");
    chk("err7_bits", total_bits, 32'd40);
    chk("err7_errs", total_bit_errors, 32'd3);

    // Saturation on the 4-bit instance; clear beats a coincident valid bit
    gen(b);
    step(b, 1'b1, 1'b1, 1'b1, 1'b0, "clrvld");
    chk("clrvld_bits", total_bits, 32'd0);
    chk("clrvld_bits_sat4", 32'(tb_s), 32'd0);
    run(13, 0, NEVER, 64'h0, "sat13");
    chk("sat13_bits_sat4", 32'(tb_s), 32'd13);
    chk("sat13_locked_sat4", 32'(locked_s), 32'd1);
    run(5, 0, NEVER, 64'h0, "sat5");
    chk("sat5_bits_sat4", 32'(tb_s), 32'd15);
    chk("sat5_bits", total_bits, 32'd18);
    chk("sat5_errs_sat4", 32'(te_s), 32'd0);
    gen(b);
    step(b, 1'b1, 1'b1, 1'b1, 1'b0, "clrsat");
    chk("clrsat_bits_sat4", 32'(tb_s), 32'd0);
    chk("clrsat_bits", total_bits, 32'd0);

    // All-zero input never locks
    prbs_sel = 2'd3;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "sel7to31");
    for (int i = 0; i < 500; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "zeros");
    chk("zeros_bits", total_bits, 32'd0);
    chk("zeros_errs", total_bit_errors, 32'd0);
`ifdef PRBS_CHK_LOSS_CNT_EN
    chk("zeros_loss", 32'(llc), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
